// File: rtl/qpsk_symbol_mapper.sv
// Serial bits -> QPSK (I,Q) samples, each symbol held for SPS clocks; next dibit refills during HOLD.
// Optional DIFF_ENC_EN macro: differential phase accumulation before mapping.
module qpsk_symbol_mapper #(
  parameter int SPS = 8,
  parameter int AMP = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_vld,
  output logic       bit_rdy,
  output logic [7:0] i_out,
  output logic [7:0] q_out,
  output logic       sym_vld,
  output logic       sym_start
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [7:0] LAST = 8'(SPS - 1);
  localparam logic [7:0] POS  = 8'(AMP);
  localparam logic [7:0] NEG  = 8'(-AMP);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pair_full_q, pair_full_d;
  logic       half_q, half_d;
  logic       b1_q, b1_d;
  logic [1:0] dibit_q, dibit_d;
  logic [7:0] i_q, i_d;
  logic [7:0] q_q, q_d;
  logic       start_q, start_d;

  logic accept;
  logic cnt_last;
  logic load;

  assign accept   = bit_vld & ~pair_full_q;
  assign cnt_last = (cnt_q == LAST);
  // A waiting pair loads from IDLE at once, or back-to-back at the end of a HOLD.
  assign load     = pair_full_q & ((state_q == IDLE) | cnt_last);

`ifdef DIFF_ENC_EN
  logic [1:0] phase_q, phase_d;
  logic [1:0] phase_nxt;
  assign phase_nxt = phase_q + dibit_q;
`endif

  // State register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pair_full_q <= 1'b0;
      half_q      <= 1'b0;
      b1_q        <= 1'b0;
      dibit_q     <= '0;
      i_q         <= '0;
      q_q         <= '0;
      start_q     <= 1'b0;
`ifdef DIFF_ENC_EN
      phase_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pair_full_q <= pair_full_d;
      half_q      <= half_d;
      b1_q        <= b1_d;
      dibit_q     <= dibit_d;
      i_q         <= i_d;
      q_q         <= q_d;
      start_q     <= start_d;
`ifdef DIFF_ENC_EN
      phase_q     <= phase_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pair_full_q) state_d = HOLD;
      HOLD: if (cnt_last && !pair_full_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    pair_full_d = pair_full_q;
    half_d      = half_q;
    b1_d        = b1_q;
    dibit_d     = dibit_q;
    i_d         = i_q;
    q_d         = q_q;
    start_d     = 1'b0;
`ifdef DIFF_ENC_EN
    phase_d     = phase_q;
`endif

    // accept and load never coincide: accept needs pair_full_q low, load needs it high
    if (accept) begin
      if (!half_q) begin
        b1_d   = bit_in;
        half_d = 1'b1;
      end else begin
        dibit_d     = {b1_q, bit_in};
        pair_full_d = 1'b1;
        half_d      = 1'b0;
      end
    end

    if (load) begin
      pair_full_d = 1'b0;
      cnt_d       = '0;
      start_d     = 1'b1;
`ifdef DIFF_ENC_EN
      phase_d = phase_nxt;
      case (phase_nxt)
        2'd0:    begin i_d = POS; q_d = POS; end
        2'd1:    begin i_d = NEG; q_d = POS; end
        2'd2:    begin i_d = NEG; q_d = NEG; end
        default: begin i_d = POS; q_d = NEG; end
      endcase
`else
      i_d = dibit_q[1] ? NEG : POS;
      q_d = dibit_q[0] ? NEG : POS;
`endif
    end else if (state_q == HOLD) begin
      cnt_d = cnt_last ? 8'd0 : cnt_q + 8'd1;
    end
  end

  // Output logic
  always_comb begin
    bit_rdy   = ~pair_full_q;
    sym_vld   = (state_q == HOLD);
    sym_start = start_q;
    i_out     = (state_q == HOLD) ? i_q : 8'd0;
    q_out     = (state_q == HOLD) ? q_q : 8'd0;
  end

endmodule
